popcount_hweval_multi: RTL and testbench

- Parametrised self-stimulating evaluation harness for the column compressor (population count) datapath.
- A 16-bit seed is expanded into IN_WIDTH-bit test vectors and pushed through a fully pipelined popcount tree for a programmed number of vectors.
- Results are compressed into a running sum and a 32-bit MISR signature, so a hardware-eval build needs only a few pins.
- The block replaces fixed-width single-shot harnesses; it adds run control, drain and done signalling.

---
 rtl/popcount_hweval_multi.sv | 214 +++++++++++++++++++++
 tb/tb_popcount_hweval_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/popcount_hweval_multi.sv
// Purpose: self-stimulating eval harness; LFSR-expanded vectors -> pipelined popcount tree -> running sum + MISR.
// Latency: accepted start to first out_valid = 3 + $clog2(LANES) cycles (8 for IN_WIDTH=512).
// Backpressure: none; one vector per RUN cycle, results drain unconditionally, start ignored while busy.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           single-cycle run request (taken in IDLE or DONE only)
//   seed, num_vec   LFSR seed and vectors per run, sampled on accepted start
//   comp_out        popcount of most recent vector, out_valid marks a fresh value
//   sum_out         accumulated popcount of the run
//   signature       32-bit MISR over the run's comp_out values
//   busy, done      run in progress / results stable
module popcount_hweval_multi #(
  parameter int  IN_WIDTH   = 512,
  parameter int  NVEC_WIDTH = 16,
  localparam int LANES      = IN_WIDTH / 16,
  localparam int OUT_WIDTH  = $clog2(IN_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [15:0]                   seed,
  input  logic [NVEC_WIDTH-1:0]         num_vec,
  output logic [OUT_WIDTH-1:0]          comp_out,
  output logic                          out_valid,
  output logic [OUT_WIDTH+NVEC_WIDTH-1:0] sum_out,
  output logic [31:0]                   signature,
  output logic                          busy,
  output logic                          done
);

  localparam int LEVELS = $clog2(LANES);
  localparam int PADDED = 1 << LEVELS;
  localparam int TW     = 5 + LEVELS;
  localparam int SW     = OUT_WIDTH + NVEC_WIDTH;
  localparam logic [NVEC_WIDTH-1:0] ONE_N = 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   start_acc;
  logic [15:0]            seed_q;
  logic [NVEC_WIDTH-1:0]  nvec_q;
  logic [NVEC_WIDTH-1:0]  cnt_q;
  logic                   last_issue;
  logic [15:0]            lfsr_q;
  logic [IN_WIDTH-1:0]    vec_nxt;
  logic [IN_WIDTH-1:0]    vec_q;
  logic                   vec_tok;
  logic [LEVELS:0]        toks;
  logic                   pipe_busy;
  logic [TW-1:0]          tree_out;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] s, input int r);
    logic [31:0] t;
    t = {s, s} << r;
    return t[31:16];
  endfunction

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int b = 0; b < 16; b++) c = c + {4'd0, v[b]};
    return c;
  endfunction

  assign start_acc  = start && (state == IDLE || state == DONE);
  // RUN is only entered with nvec_q != 0, so nvec_q - 1 never wraps here.
  assign last_issue = (cnt_q == nvec_q - ONE_N);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = (nvec_q == '0) ? DRAIN : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      // The last token may sit in the final stage now; it leaves on this edge.
      DRAIN:   if (!pipe_busy) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  // ---------------- run parameters, LFSR, vector counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q <= '0;
      nvec_q <= '0;
    end else if (start_acc) begin
      seed_q <= seed;
      nvec_q <= num_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
      cnt_q  <= '0;
    end else if (state == LOAD) begin
      // All-zero is the LFSR lock-up state, so it is mapped to 1.
      lfsr_q <= (seed_q == 16'h0000) ? 16'h0001 : seed_q;
      cnt_q  <= '0;
    end else if (state == RUN) begin
      lfsr_q <= lfsr_next(lfsr_q);
      cnt_q  <= cnt_q + ONE_N;
    end
  end

  // ---------------- vector expansion ----------------
  always_comb begin
    vec_nxt = '0;
    for (int k = 0; k < LANES; k++)
      vec_nxt[16*k +: 16] = rotl16(lfsr_q, k % 16) ^ 16'(k);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q   <= '0;
      vec_tok <= 1'b0;
    end else begin
      vec_tok <= (state == RUN);
      if (state == RUN) vec_q <= vec_nxt;
    end
  end

  // ---------------- popcount pipeline ----------------
  // Level 0 holds per-lane counts; each further level adds pairs.
  // Lane count is padded to a power of two with zero leaves.
  // Data registers only load with a token so the output holds between runs.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = PADDED >> l;
    localparam int W = 5 + l;
    logic [W-1:0] d [N];
    logic         tok;

    assign toks[l] = tok;

    if (l == 0) begin : g_leaf
      logic [4:0] cnt [N];
      for (genvar i = 0; i < N; i++) begin : g_lane
        if (i < LANES) begin : g_real
          assign cnt[i] = popcnt16(vec_q[16*i +: 16]);
        end else begin : g_pad
          assign cnt[i] = '0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tok <= 1'b0;
          for (int j = 0; j < N; j++) d[j] <= '0;
        end else begin
          tok <= vec_tok;
          if (vec_tok)
            for (int j = 0; j < N; j++) d[j] <= cnt[j];
        end
      end
    end else begin : g_node
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tok <= 1'b0;
          for (int j = 0; j < N; j++) d[j] <= '0;
        end else begin
          tok <= g_lvl[l-1].tok;
          if (g_lvl[l-1].tok)
            for (int j = 0; j < N; j++)
              d[j] <= {1'b0, g_lvl[l-1].d[2*j]} + {1'b0, g_lvl[l-1].d[2*j+1]};
        end
      end
    end
  end

  assign tree_out  = g_lvl[LEVELS].d[0];
  assign out_valid = toks[LEVELS];
  // Tokens still upstream of the final stage keep DRAIN alive.
  assign pipe_busy = vec_tok | (|toks[LEVELS-1:0]);

  // The true maximum (IN_WIDTH) always fits OUT_WIDTH, so truncation is lossless.
  if (TW >= OUT_WIDTH) begin : g_trunc
    assign comp_out = tree_out[OUT_WIDTH-1:0];
  end else begin : g_ext
    assign comp_out = {{(OUT_WIDTH-TW){1'b0}}, tree_out};
  end

  // ---------------- result compression ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_out   <= '0;
      signature <= '0;
    end else if (state == LOAD) begin
      sum_out   <= '0;
      signature <= '0;
    end else if (out_valid) begin
      sum_out   <= sum_out + SW'(comp_out);
      signature <= {signature[30:0],
                    signature[31] ^ signature[21] ^ signature[1] ^ signature[0]}
                   ^ 32'(comp_out);
    end
  end

endmodule

// File: tb/tb_popcount_hweval_multi.sv
// Directed bench for popcount_hweval_multi: table of runs plus reset/idle sequences.
module tb_popcount_hweval_multi;

  localparam int IN_WIDTH   = 512;
  localparam int NVEC_WIDTH = 16;
  localparam int OUT_WIDTH  = 10;
  localparam int SW         = OUT_WIDTH + NVEC_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [15:0]           seed;
  logic [NVEC_WIDTH-1:0] num_vec;
  logic [OUT_WIDTH-1:0]  comp_out;
  logic                  out_valid;
  logic [SW-1:0]         sum_out;
  logic [31:0]           signature;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  popcount_hweval_multi #(.IN_WIDTH(IN_WIDTH), .NVEC_WIDTH(NVEC_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .num_vec   (num_vec),
    .comp_out  (comp_out),
    .out_valid (out_valid),
    .sum_out   (sum_out),
    .signature (signature),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int m_pop(input logic [15:0] s);
    int          p;
    int          r;
    logic [15:0] rot;
    logic [15:0] lane;
    p = 0;
    for (int k = 0; k < IN_WIDTH / 16; k++) begin
      r    = k % 16;
      rot  = (r == 0) ? s : ((s << r) | (s >> (16 - r)));
      lane = rot ^ 16'(k);
      p   += $countones(lane);
    end
    return p;
  endfunction

  // One run from IDLE/DONE; hsum/hsig < 0 means "use the model's totals".
  task automatic run_vec(input logic [15:0] sd, input int nv, input longint hsum,
                         input longint hsig, input bit mid);
    int          exp_pop[$];
    int          e_sum;
    logic [31:0] e_sig;
    logic [15:0] s;
    int          p;
    int          cyc;
    int          first;
    int          idx;
    int          gap;
    int          done_cyc;

    e_sum = 0;
    e_sig = '0;
    s     = (sd == 16'h0000) ? 16'h0001 : sd;
    for (int i = 0; i < nv; i++) begin
      p = m_pop(s);
      exp_pop.push_back(p);
      e_sum += p;
      e_sig  = {e_sig[30:0], e_sig[31] ^ e_sig[21] ^ e_sig[1] ^ e_sig[0]} ^ 32'(p);
      s      = m_next(s);
    end

    @(negedge clk);
    seed    = sd;
    num_vec = NVEC_WIDTH'(nv);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    seed    = 16'($urandom);
    num_vec = NVEC_WIDTH'($urandom);

    cyc = 0; first = -1; idx = 0; gap = 0; done_cyc = -1;
    chk("busy_after_start", busy, 1);
    while (cyc < nv + 40) begin
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (cyc != first + idx) gap++;
        if (idx < nv) chk("comp_out", comp_out, exp_pop[idx]);
        idx++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = (mid && cyc == 100);
      if (start) seed = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    if (nv > 0) chk("first_valid_latency", first, 8);
    chk("valid_count", idx, nv);
    chk("valid_contiguous_gaps", gap, 0);
    chk("done_cycle", done_cyc, (nv == 0) ? 2 : 8 + nv);
    chk("sum_out", sum_out, (hsum >= 0) ? hsum : longint'(e_sum));
    chk("signature", signature, (hsig >= 0) ? hsig : longint'(e_sig));
    chk("busy_in_done", busy, 0);
  endtask

  typedef struct {
    logic [15:0] seed;
    int          nvec;
    longint      hsum;
    longint      hsig;
    bit          mid;
  } run_t;

  run_t tbl[8];

  initial begin
    bit any_valid;
    bit any_busy;

    // Hand values: seed FFFF -> 512 - 80 = 432; seed 1 -> 48 + 62 = 110.
    tbl[0] = '{16'hFFFF, 1,    432, 'h1B0, 1'b0};
    tbl[1] = '{16'h0001, 1,    110, 'h06E, 1'b0};
    tbl[2] = '{16'h0000, 1,    110, 'h06E, 1'b0};
    tbl[3] = '{16'h0000, 4,     -1,    -1, 1'b0};
    tbl[4] = '{16'h0001, 4,     -1,    -1, 1'b0};
    tbl[5] = '{16'($urandom_range(1, 65535)), 1000, -1, -1, 1'b1};
    tbl[6] = '{16'h0000, 0,      0,     0, 1'b0};
    tbl[7] = '{16'h1234, 3,     -1,    -1, 1'b0};

    reset   = 1'b1;
    start   = 1'b0;
    seed    = '0;
    num_vec = '0;
    repeat (3) @(negedge clk);
    chk("rst_comp_out", comp_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_signature", signature, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    any_valid = 1'b0;
    any_busy  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_valid |= out_valid;
      any_busy  |= busy | done;
    end
    chk("idle_no_valid", any_valid, 0);
    chk("idle_not_busy", any_busy, 0);

    // Entries run back to back, so every run after the first restarts from DONE.
    for (int t = 0; t < 8; t++)
      run_vec(tbl[t].seed, tbl[t].nvec, tbl[t].hsum, tbl[t].hsig, tbl[t].mid);

    // Reset while vector 37 is being issued.
    @(negedge clk);
    seed    = 16'h5A5A;
    num_vec = 16'd200;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (38) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_sum_nonzero", (sum_out != 0), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_comp_out", comp_out, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum_out", sum_out, 0);
    chk("mid_rst_signature", signature, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(16'h5A5A, 50, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
